// File: rtl/ps2_key_decoder_pkg.sv
// Shared types and constants for the PS/2 key decoder.
package ps2_pkg;

  localparam int SOUND_CODE_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_e;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  localparam logic [7:0] KEY_0 = 8'h45;
  localparam logic [7:0] KEY_1 = 8'h16;
  localparam logic [7:0] KEY_2 = 8'h1E;
  localparam logic [7:0] KEY_3 = 8'h26;
  localparam logic [7:0] KEY_4 = 8'h25;
  localparam logic [7:0] KEY_5 = 8'h2E;
  localparam logic [7:0] KEY_6 = 8'h36;
  localparam logic [7:0] KEY_7 = 8'h3D;
  localparam logic [7:0] KEY_8 = 8'h3E;
  localparam logic [7:0] KEY_9 = 8'h46;
  localparam logic [7:0] KEY_A = 8'h1C;
  localparam logic [7:0] KEY_B = 8'h32;
  localparam logic [7:0] KEY_C = 8'h21;
  localparam logic [7:0] KEY_D = 8'h23;
  localparam logic [7:0] KEY_E = 8'h24;
  localparam logic [7:0] KEY_F = 8'h2B;

  // Returns {hit, sound_code}; hit=0 for keys outside 0-9/A-F.
  function automatic logic [SOUND_CODE_W:0] key_lookup(input logic [7:0] code);
    logic [SOUND_CODE_W:0] res;
    res = '0;
    case (code)
      KEY_0: res = {1'b1, 4'h0};
      KEY_1: res = {1'b1, 4'h1};
      KEY_2: res = {1'b1, 4'h2};
      KEY_3: res = {1'b1, 4'h3};
      KEY_4: res = {1'b1, 4'h4};
      KEY_5: res = {1'b1, 4'h5};
      KEY_6: res = {1'b1, 4'h6};
      KEY_7: res = {1'b1, 4'h7};
      KEY_8: res = {1'b1, 4'h8};
      KEY_9: res = {1'b1, 4'h9};
      KEY_A: res = {1'b1, 4'hA};
      KEY_B: res = {1'b1, 4'hB};
      KEY_C: res = {1'b1, 4'hC};
      KEY_D: res = {1'b1, 4'hD};
      KEY_E: res = {1'b1, 4'hE};
      KEY_F: res = {1'b1, 4'hF};
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_frame_rx.sv
// PS/2 frame receiver: synchroniser, falling-edge detect, frame FSM,
// parity/stop check and inter-edge watchdog. Strobes are combinational
// in the cycle the stop-bit edge is seen; the caller registers them.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_vld_o,
  output logic       rx_err_o
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   clk_prev_q;
  frame_state_e           state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d;
  logic [WD_W-1:0]        wd_q, wd_d;

  logic clk_s, dat_s, fall;

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];
  assign fall  = clk_prev_q & ~clk_s;

  // Synchronisers and previous-clock flop; idle-high bus so reset to 1.
  always_ff @(posedge clock_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_i};
      clk_prev_q <= clk_s;
    end
  end

  // Frame FSM and datapath registers.
  always_ff @(posedge clock_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      wd_q      <= wd_d;
    end
  end

  // Next-state: advance on each falling edge, abandon the frame on watchdog expiry.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    wd_d      = '0;
    rx_vld_o  = 1'b0;
    rx_err_o  = 1'b0;
    if (state_q != IDLE) wd_d = wd_q + WD_W'(1);
    if (fall) begin
      wd_d = '0;
      case (state_q)
        IDLE: begin
          // A falling edge with data high is treated as a glitch.
          if (!dat_s) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d   = {dat_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_s;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (dat_s && ((^shift_q) ^ par_q)) rx_vld_o = 1'b1;
          else                               rx_err_o = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
      state_d = IDLE;
      wd_d    = '0;
    end
  end

  assign rx_byte_o = shift_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 key decoder: filters break/extended sequences and maps hex-key
// make codes to a 4-bit sound code with a one-cycle strobe.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ps2_clk,
  input  logic                    ps2_dat,
  output logic [SOUND_CODE_W-1:0] ps2_data,
  output logic                    ps2_en,
  output logic                    frame_err
);

  logic [7:0] rx_byte;
  logic       rx_vld, rx_err;

  logic                    brk_q, brk_d;
  logic                    ext_q, ext_d;
  logic [SOUND_CODE_W-1:0] data_q, data_d;
  logic                    en_q, en_d;
  logic                    err_q, err_d;
  logic [SOUND_CODE_W:0]   lut;

  ps2_frame_rx #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_frame_rx (
    .clock_i   (clock),
    .rst_ni    (reset),
    .ps2_clk_i (ps2_clk),
    .ps2_dat_i (ps2_dat),
    .rx_byte_o (rx_byte),
    .rx_vld_o  (rx_vld),
    .rx_err_o  (rx_err)
  );

  // Flag and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      brk_q  <= 1'b0;
      ext_q  <= 1'b0;
      data_q <= '0;
      en_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      brk_q  <= brk_d;
      ext_q  <= ext_d;
      data_q <= data_d;
      en_q   <= en_d;
      err_q  <= err_d;
    end
  end

  // Byte decode: prefixes set flags, the byte after a prefix is swallowed.
  always_comb begin
    brk_d  = brk_q;
    ext_d  = ext_q;
    data_d = data_q;
    en_d   = 1'b0;
    err_d  = rx_err;
    lut    = key_lookup(rx_byte);
    if (rx_vld) begin
      if (rx_byte == BREAK_CODE) begin
        brk_d = 1'b1;
      end else if (rx_byte == EXT_CODE) begin
        ext_d = 1'b1;
      end else if (brk_q || ext_q) begin
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else if (lut[SOUND_CODE_W]) begin
        data_d = lut[SOUND_CODE_W-1:0];
        en_d   = 1'b1;
      end
    end
  end

  assign ps2_data  = data_q;
  assign ps2_en    = en_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder. System clock 2.5 MHz so that a
// 20 us PS/2 bit period (50 clocks) fits inside TIMEOUT_CYC=100.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

  localparam int TIMEOUT = 100;
  localparam int K_DATA = 0;
  localparam int K_ERR  = 1;
  localparam int K_NONE = 2;

  typedef struct {
    int         kind;
    logic [3:0] val;
    longint     cyc;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [3:0] ps2_data;
  logic       ps2_en;
  logic       frame_err;

  int     tests = 0;
  int     fails = 0;
  longint cyc = 0;
  exp_t   exp_q[$];
  logic   en_prev = 1'b0;

  ps2_key_decoder #(.TIMEOUT_CYC(TIMEOUT), .SYNC_STAGES(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .ps2_data  (ps2_data),
    .ps2_en    (ps2_en),
    .frame_err (frame_err)
  );

  always #200 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sends bits[0..nbits-1] of {stop, parity, data, start}; the expected
  // response is queued at the stop-bit falling edge (2 sync + 1 output reg).
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                            input int nbits, input int kind, input logic [3:0] val);
    logic [10:0] bits;
    exp_t e;
    bits = {stp, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      tick(12);
      ps2_clk = 1'b0;
      if (i == 10 && kind != K_NONE) begin
        e.kind = kind;
        e.val  = val;
        e.cyc  = cyc + 3;
        exp_q.push_back(e);
      end
      tick(25);
      ps2_clk = 1'b1;
      tick(13);
    end
    ps2_dat = 1'b1;
  endtask

  function automatic logic odd_par(input logic [7:0] b);
    return ~(^b);
  endfunction

  task automatic key(input logic [7:0] b, input int kind, input logic [3:0] val);
    send_frame(b, odd_par(b), 1'b1, 11, kind, val);
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes.
  always @(negedge clock) begin
    if (reset) begin
      if (ps2_en && frame_err) begin
        fails++;
        $display("FAIL en_err_overlap: ps2_en=%0b frame_err=%0b expected not both", ps2_en, frame_err);
      end
      if (ps2_en && en_prev) begin
        fails++;
        $display("FAIL en_double: ps2_en high two cycles at cycle %0d", cyc);
      end
      if (ps2_en || frame_err) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_strobe: en=%0b err=%0b data=%0h at cycle %0d, none expected",
                   ps2_en, frame_err, ps2_data, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if ((e.kind == K_DATA) !== ps2_en || (e.kind == K_ERR) !== frame_err) begin
            fails++;
            $display("FAIL strobe_kind: en=%0b err=%0b expected kind %0d", ps2_en, frame_err, e.kind);
          end else if (e.kind == K_DATA && ps2_data !== e.val) begin
            fails++;
            $display("FAIL strobe_data: got %0h expected %0h", ps2_data, e.val);
          end else if (cyc != e.cyc) begin
            fails++;
            $display("FAIL strobe_latency: at cycle %0d expected cycle %0d", cyc, e.cyc);
          end
        end
      end
    end
    en_prev <= ps2_en;
  end

  initial begin
    tick(5);
    check("reset_data", {4'h0, ps2_data}, 8'h00);
    check("reset_en", {7'h0, ps2_en}, 8'h00);
    check("reset_err", {7'h0, frame_err}, 8'h00);
    reset = 1'b1;
    tick(5);

    key(8'h1E, K_DATA, 4'h2);
    tick(20);
    check("data_after_1E", {4'h0, ps2_data}, 8'h02);

    key(8'h2B, K_DATA, 4'hF);
    key(8'hF0, K_NONE, 4'h0);
    key(8'h2B, K_NONE, 4'h0);
    tick(20);
    check("data_hold_F", {4'h0, ps2_data}, 8'h0F);

    key(8'hE0, K_NONE, 4'h0);
    key(8'h16, K_NONE, 4'h0);
    key(8'h16, K_DATA, 4'h1);
    tick(20);
    check("data_after_16", {4'h0, ps2_data}, 8'h01);

    send_frame(8'h25, 1'b1, 1'b1, 11, K_ERR, 4'h0);
    tick(20);
    check("data_hold_par_err", {4'h0, ps2_data}, 8'h01);
    send_frame(8'h25, 1'b0, 1'b0, 11, K_ERR, 4'h0);
    tick(20);
    check("data_hold_stop_err", {4'h0, ps2_data}, 8'h01);

    send_frame(8'h45, 1'b0, 1'b1, 5, K_NONE, 4'h0);
    tick(TIMEOUT + 50);
    key(8'h45, K_DATA, 4'h0);
    tick(20);

    key(8'h2B, K_DATA, 4'hF);
    tick(20);
    send_frame(8'h46, odd_par(8'h46), 1'b1, 5, K_NONE, 4'h0);
    reset = 1'b0;
    #1;
    check("midreset_data", {4'h0, ps2_data}, 8'h00);
    check("midreset_en", {7'h0, ps2_en}, 8'h00);
    tick(3);
    reset = 1'b1;
    tick(5);
    key(8'h3D, K_DATA, 4'h7);
    key(8'h5A, K_NONE, 4'h0);
    tick(100);
    check("data_final", {4'h0, ps2_data}, 8'h07);
    check("queue_empty", 8'(exp_q.size()), 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
